systolic_result_writeback: RTL and testbench
============================================

// Module: systolic_result_writeback
// PURPOSE
//  Downstream stage of the 8x8 systolic-array driver. On start (driver done pulse), snapshots
//  the 8x8 result tile and streams it to result memory as 16 write beats of WRITE_BW words,
//  row-major. Row stride is dim_col_C; a stalling memory applies back-pressure via wait_req.
// PARAMETERS
//  DATA_WIDTH  32  bits per matrix element
//  ADDR_WIDTH  12  memory word-address width
//  DIM_WIDTH   6   width of dim_col_C
//  TILE        8   tile edge; fixed at 8
//  WRITE_BW    4   words per write beat; TILE must be a multiple of WRITE_BW
// PORTS
//  clock       in   1                          clock
//  reset       in   1                          reset, asynchronous, active-high
//  start       in   1                          1-cycle pulse: tile_in valid, begin writeback
//  tile_in     in   [TILE][TILE][DATA_WIDTH]   result tile, [row][col]
//  base_C      in   ADDR_WIDTH                 address of C[0][0]; sampled on start
//  dim_col_C   in   DIM_WIDTH                  C row stride in words; sampled on start
//  wait_req    in   1                          memory stall; beat accepted when write && !wait_req
//  write       out  1                          write beat valid
//  write_addr  out  ADDR_WIDTH                 word address of writedata[0]
//  writedata   out  [WRITE_BW][DATA_WIDTH]     writedata[k] goes to write_addr+k
//  busy        out  1                          high from cycle after start until done
//  done        out  1                          1-cycle pulse after the last beat is accepted
//  overrun     out  1                          1-cycle pulse when start arrives while busy
// BEHAVIOUR
//  - Reset (async): state=IDLE. write, busy, done and overrun are 0; write_addr and writedata
//    are 0. The tile buffer is not reset.
//  - IDLE: on start, capture tile_in, base_C and dim_col_C; clear beat counter; go to WRITE.
//  - WRITE: beat b (0..15) has row r=b>>1 and half h=b&1.
//    write_addr = row_base + 4*h, where row_base = base_C + r*dim_col_C.
//    writedata[k] = tile[r][4*h+k].
//  - row_base is an accumulator: loaded with base_C on start, incremented by dim_col_C after
//    each accepted h=1 beat. No multiplier is used.
//  - write stays high throughout WRITE. While wait_req=1, write_addr and writedata hold.
//    The beat advances only on write && !wait_req.
//  - When beat 15 is accepted: go to DONE. DONE asserts done for 1 cycle, then returns to IDLE.
//  - Latency with no stalls: start at cycle t -> first beat at t+1 -> last beat at t+16 ->
//    done at t+17. Each stall cycle adds 1.
//  - Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
//  - dim_col_C=0 is legal: all rows write the same two addresses.
//  - start while busy (WRITE or DONE): ignored, with no change to the tile, addresses or
//    counter; overrun pulses for 1 cycle.
//  - start in the same cycle done is high: counts as overrun. The new start is accepted only
//    in IDLE.
//  - Reset asserted mid-writeback: abort immediately, with no done pulse. The beat in flight
//    is dropped (write=0 asynchronously).
//  - tile_in may change freely after the start cycle.
// CONFIGURATION
//  - WB_RELU_EN defined: each writedata word = (signed word < 0) ? 0 : word. The clamp is
//    applied at capture, so there is no added latency.
//  - WB_RELU_EN undefined: words are passed through unmodified.
//  - Timing and handshake are identical in both builds.
// STRUCTURE
//  - Shared package fpga_torch_pkg holds:
//    - constants DATA_WIDTH, ADDR_WIDTH, DIM_WIDTH, TILE, WRITE_BW;
//    - typedef elem_t (logic [DATA_WIDTH-1:0]);
//    - typedef tile_t ([TILE][TILE] elem_t);
//    - enum wb_state_t {IDLE, WRITE, DONE}.
//  - One sub-module: writeback_addr_gen. It contains the row_base accumulator and the h
//    offset, takes load/advance/half inputs and outputs write_addr.
//  - FSM, beat counter and tile buffer live in the top module.
// TESTING
//  1. tile[r][c]=16r+c, base_C=0x100, dim_col_C=8, wait_req=0
//     -> 16 beats at 0x100,0x104,0x108,...,0x13C; beat 0 data {0,1,2,3};
//        beat 15 data {116,117,118,119}; done at start+17.
//  2. Same as 1, but wait_req=1 for 3 cycles on beat 5
//     -> beat 5 (addr 0x114, data {36..39}) is held stable for 4 cycles; done at start+20.
//  3. base_C=0xFFC, dim_col_C=16
//     -> beat 0 at 0xFFC, beat 1 at 0x000, beat 2 at 0x00C (wrap-around).
//  4. Second start pulse at beat 7 with a different tile
//     -> overrun=1 for 1 cycle; all 16 beats carry the original tile; exactly one done.
//  5. reset asserted at beat 9
//     -> write=0, busy=0 immediately; no done; a later start runs a clean 16-beat writeback.
//  6. WB_RELU_EN build, tile word 0xFFFFFFF6 (-10) at [2][5]
//     -> beat 5 writedata[1]=0; in the non-RELU build it is 0xFFFFFFF6.

Source files
------------

// File: rtl/fpga_torch_pkg.sv
// -----------------------------------------------------------------------------
// fpga_torch_pkg
// Shared constants, types and helpers for the systolic-array result path.
//   DATA_WIDTH : bits per matrix element
//   ADDR_WIDTH : memory word-address width
//   DIM_WIDTH  : width of the C row stride
//   TILE       : tile edge (fixed at 8)
//   WRITE_BW   : words per write beat (TILE is a multiple of WRITE_BW)
// Derived: SEGS beats per tile row, BEATS beats per tile, BEAT_W counter width.
// -----------------------------------------------------------------------------
package fpga_torch_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 12;
    localparam int DIM_WIDTH  = 6;
    localparam int TILE       = 8;
    localparam int WRITE_BW   = 4;

    localparam int SEGS   = TILE / WRITE_BW;
    localparam int BEATS  = TILE * SEGS;
    localparam int BEAT_W = $clog2(BEATS);

    typedef logic [DATA_WIDTH-1:0]     elem_t;
    typedef elem_t [TILE-1:0][TILE-1:0] tile_t;
    typedef elem_t [WRITE_BW-1:0]      wdata_t;
    typedef logic [ADDR_WIDTH-1:0]     addr_t;
    typedef logic [DIM_WIDTH-1:0]      dim_t;
    typedef logic [BEAT_W-1:0]         beat_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wb_state_t;

    // Words carried by beat b: row b/SEGS, columns starting at (b%SEGS)*WRITE_BW.
    function automatic wdata_t beat_slice(input tile_t t, input beat_idx_t b);
        wdata_t s;
        int     r;
        int     c0;
        r  = int'(b) / SEGS;
        c0 = (int'(b) % SEGS) * WRITE_BW;
        for (int k = 0; k < WRITE_BW; k++) begin
            s[k] = t[r][c0 + k];
        end
        return s;
    endfunction

    // True when beat b is the last segment of its row (row stride applies next).
    function automatic logic is_row_end(input beat_idx_t b);
        return ((int'(b) % SEGS) == (SEGS - 1));
    endfunction

endpackage

// File: rtl/systolic_result_writeback_addr_gen.sv
// -----------------------------------------------------------------------------
// writeback_addr_gen
// Write-address generator for the result writeback stream. Keeps a row_base
// accumulator (no multiplier): loaded with base on load, bumped by the captured
// row stride after an accepted beat that ends a row. Within a row the address
// steps by WRITE_BW words per accepted beat. The address is registered so it
// holds while the memory stalls. Arithmetic wraps modulo 2^ADDR_WIDTH.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   load         : capture base/dim and restart at base
//   advance      : current beat accepted (write && !wait_req)
//   half         : current beat is the last segment of its row
//   base, dim    : C[0][0] address and row stride, sampled on load
//   write_addr   : word address of the beat being presented
// -----------------------------------------------------------------------------
module writeback_addr_gen
    import fpga_torch_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  load,
    input  logic  advance,
    input  logic  half,
    input  addr_t base,
    input  dim_t  dim,
    output addr_t write_addr
);

    addr_t row_base_r;
    addr_t addr_r;
    dim_t  dim_r;
    addr_t next_row_s;
    addr_t next_seg_s;

    // Candidate addresses for the next beat: start of next row or next segment.
    always_comb begin
        next_row_s = row_base_r + {{(ADDR_WIDTH-DIM_WIDTH){1'b0}}, dim_r};
        next_seg_s = addr_r + addr_t'(WRITE_BW);
    end

    // Accumulator, stride and presented-address registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_base_r <= {ADDR_WIDTH{1'b0}};
            addr_r     <= {ADDR_WIDTH{1'b0}};
            dim_r      <= {DIM_WIDTH{1'b0}};
        end else if (load) begin
            row_base_r <= base;
            addr_r     <= base;
            dim_r      <= dim;
        end else if (advance) begin
            if (half) begin
                row_base_r <= next_row_s;
                addr_r     <= next_row_s;
            end else begin
                addr_r     <= next_seg_s;
            end
        end else begin
            row_base_r <= row_base_r;
            addr_r     <= addr_r;
            dim_r      <= dim_r;
        end
    end

    assign write_addr = addr_r;

endmodule

// File: rtl/systolic_result_writeback.sv
// -----------------------------------------------------------------------------
// systolic_result_writeback
// On a start pulse, snapshots an 8x8 result tile and streams it to result
// memory as 16 row-major write beats of WRITE_BW words, honouring wait_req
// back-pressure. done pulses once after the last beat is accepted; a start
// that arrives while busy is ignored and flagged on overrun.
// Optional build macro:
//   WB_RELU_EN : negative (signed) words are clamped to zero at capture time.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   start        : 1-cycle pulse, tile_in/base_C/dim_col_C valid
//   tile_in      : result tile [row][col]
//   base_C       : address of C[0][0]
//   dim_col_C    : C row stride in words
//   wait_req     : memory stall; a beat is accepted on write && !wait_req
//   write        : write beat valid
//   write_addr   : word address of writedata[0]
//   writedata    : writedata[k] goes to write_addr+k
//   busy         : high from the cycle after start through the done cycle
//   done         : 1-cycle pulse after the last beat is accepted
//   overrun      : 1-cycle pulse when start arrives while busy
// -----------------------------------------------------------------------------
module systolic_result_writeback
    import fpga_torch_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   start,
    input  tile_t  tile_in,
    input  addr_t  base_C,
    input  dim_t   dim_col_C,
    input  logic   wait_req,
    output logic   write,
    output addr_t  write_addr,
    output wdata_t writedata,
    output logic   busy,
    output logic   done,
    output logic   overrun
);

    wb_state_t state_r;
    wb_state_t state_s;
    tile_t     tile_r;
    tile_t     captured_s;
    beat_idx_t beat_r;
    logic      load_s;
    logic      accept_s;
    logic      last_beat_s;
    logic      row_end_s;
    logic      write_s;
    logic      busy_s;
    logic      done_s;
    logic      overrun_s;
    wdata_t    writedata_s;

    // Word conditioning applied once, at capture, so the stream adds no latency.
    function automatic tile_t condition_tile(input tile_t t);
        tile_t o;
        for (int r = 0; r < TILE; r++) begin
            for (int c = 0; c < TILE; c++) begin
`ifdef WB_RELU_EN
                if (t[r][c][DATA_WIDTH-1]) begin
                    o[r][c] = {DATA_WIDTH{1'b0}};
                end else begin
                    o[r][c] = t[r][c];
                end
`else
                o[r][c] = t[r][c];
`endif
            end
        end
        return o;
    endfunction

    // Handshake decode shared by FSM, counter, data path and address generator.
    always_comb begin
        captured_s  = condition_tile(tile_in);
        load_s      = (state_r == IDLE) && start;
        accept_s    = write && !wait_req;
        last_beat_s = (beat_r == beat_idx_t'(BEATS - 1));
        row_end_s   = is_row_end(beat_r);
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = WRITE;
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                if (accept_s && last_beat_s) begin
                    state_s = DONE;
                end else begin
                    state_s = WRITE;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM output logic: next values of the registered status outputs.
    always_comb begin
        write_s   = 1'b0;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        overrun_s = start && (state_r != IDLE);
        case (state_s)
            IDLE: begin
                write_s = 1'b0;
                busy_s  = 1'b0;
            end
            WRITE: begin
                write_s = 1'b1;
                busy_s  = 1'b1;
            end
            DONE: begin
                busy_s  = 1'b1;
                done_s  = 1'b1;
            end
            default: begin
                write_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Next write data: first beat comes straight from the conditioned input
    // (the buffer is being loaded on the same edge); later beats from the buffer.
    always_comb begin
        if (load_s) begin
            writedata_s = beat_slice(captured_s, {BEAT_W{1'b0}});
        end else if (accept_s && !last_beat_s) begin
            writedata_s = beat_slice(tile_r, beat_r + beat_idx_t'(1));
        end else begin
            writedata_s = writedata;
        end
    end

    // Registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            writedata <= {(WRITE_BW*DATA_WIDTH){1'b0}};
        end else begin
            write     <= write_s;
            busy      <= busy_s;
            done      <= done_s;
            overrun   <= overrun_s;
            writedata <= writedata_s;
        end
    end

    // Beat counter: cleared on accepted start, advanced on each accepted beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_r <= {BEAT_W{1'b0}};
        end else if (load_s) begin
            beat_r <= {BEAT_W{1'b0}};
        end else if (accept_s && !last_beat_s) begin
            beat_r <= beat_r + beat_idx_t'(1);
        end else begin
            beat_r <= beat_r;
        end
    end

    // Tile buffer: deliberately not reset, only written by an accepted start.
    always_ff @(posedge clock) begin
        if (load_s) begin
            tile_r <= captured_s;
        end else begin
            tile_r <= tile_r;
        end
    end

    writeback_addr_gen u_addr_gen (
        .clock      (clock),
        .reset      (reset),
        .load       (load_s),
        .advance    (accept_s),
        .half       (row_end_s),
        .base       (base_C),
        .dim        (dim_col_C),
        .write_addr (write_addr)
    );

endmodule

// File: tb/tb_systolic_result_writeback.sv
// -----------------------------------------------------------------------------
// tb_systolic_result_writeback
// Scoreboard bench for systolic_result_writeback. Each accepted start pushes
// its 16 expected beats and expected done cycle; a monitor on the falling edge
// compares every presented beat, done and overrun pulse against the queues.
// Build with WB_RELU_EN defined to check the clamping variant.
// -----------------------------------------------------------------------------
module tb_systolic_result_writeback;
    import fpga_torch_pkg::*;

    typedef struct {
        addr_t  addr;
        wdata_t data;
    } exp_beat_t;

    logic   clock = 1'b0;
    logic   reset;
    logic   start;
    tile_t  tile_in;
    addr_t  base_C;
    dim_t   dim_col_C;
    logic   wait_req;
    logic   write;
    addr_t  write_addr;
    wdata_t writedata;
    logic   busy;
    logic   done;
    logic   overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_beat_t beat_q[$];
    int        done_q[$];
    int        ovr_q[$];
    exp_beat_t mon_e;

    tile_t tile_a;
    tile_t tile_b;
    tile_t tile_c;

    systolic_result_writeback dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .tile_in    (tile_in),
        .base_C     (base_C),
        .dim_col_C  (dim_col_C),
        .wait_req   (wait_req),
        .write      (write),
        .write_addr (write_addr),
        .writedata  (writedata),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_ev(input string nm);
        total++;
        bad++;
        $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
    endtask

    function automatic elem_t exp_word(input tile_t t, input int r, input int c);
        elem_t w;
        w = t[r][c];
`ifdef WB_RELU_EN
        if ($signed(w) < 0) w = 32'd0;
`endif
        return w;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drive one start pulse and push the expected stream for it.
    task automatic issue_start(input tile_t t, input addr_t b, input dim_t d, input int stalls);
        exp_beat_t e;
        int        t0;
        tile_in   = t;
        base_C    = b;
        dim_col_C = d;
        start     = 1'b1;
        t0        = cyc;
        for (int bt = 0; bt < BEATS; bt++) begin
            int r = bt / SEGS;
            int h = bt % SEGS;
            int a = int'(b) + r * int'(d) + h * WRITE_BW;
            e.addr = a[ADDR_WIDTH-1:0];
            for (int k = 0; k < WRITE_BW; k++) e.data[k] = exp_word(t, r, h * WRITE_BW + k);
            beat_q.push_back(e);
        end
        done_q.push_back(t0 + 17 + stalls);
        wait_cycles(1);
        start     = 1'b0;
        tile_in   = ~t;
        base_C    = ~b;
        dim_col_C = ~d;
    endtask

    // Monitor / scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            if (write) begin
                if (beat_q.size() == 0) begin
                    fail_ev("extra_beat");
                end else begin
                    mon_e = beat_q[0];
                    chk("beat_addr", 128'(write_addr), 128'(mon_e.addr));
                    chk("beat_data", 128'(writedata), 128'(mon_e.data));
                    if (!wait_req) void'(beat_q.pop_front());
                end
            end
            if (done) begin
                if (done_q.size() == 0) fail_ev("extra_done");
                else chk("done_cycle", 128'(cyc), 128'(done_q.pop_front()));
            end
            if (overrun) begin
                if (ovr_q.size() == 0) fail_ev("extra_overrun");
                else chk("overrun_cycle", 128'(cyc), 128'(ovr_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        tile_in   = '0;
        base_C    = '0;
        dim_col_C = '0;
        wait_req  = 1'b0;
        for (int r = 0; r < TILE; r++) begin
            for (int c = 0; c < TILE; c++) begin
                tile_a[r][c] = 32'(16 * r + c);
                tile_b[r][c] = 32'hDEAD_0000 + 32'(r * 8 + c);
                tile_c[r][c] = 32'(1000 + 16 * r + c);
            end
        end
        tile_c[2][5] = 32'hFFFF_FFF6;

        // Reset state.
        wait_cycles(3);
        chk("rst_write", 128'(write), 128'(1'b0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_done", 128'(done), 128'(1'b0));
        chk("rst_overrun", 128'(overrun), 128'(1'b0));
        chk("rst_addr", 128'(write_addr), 128'(12'h000));
        chk("rst_data", 128'(writedata), 128'(0));
        reset = 1'b0;
        wait_cycles(2);

        // 1: plain stream, 0x100 stride 8.
        issue_start(tile_a, 12'h100, 6'd8, 0);
        chk("t1_busy", 128'(busy), 128'(1'b1));
        wait_cycles(18);
        chk("t1_idle_busy", 128'(busy), 128'(1'b0));
        wait_cycles(2);

        // 2: three stall cycles on beat 5.
        issue_start(tile_a, 12'h100, 6'd8, 3);
        wait_cycles(5);
        wait_req = 1'b1;
        wait_cycles(3);
        wait_req = 1'b0;
        wait_cycles(16);

        // 3: address wrap-around.
        issue_start(tile_a, 12'hFFC, 6'd16, 0);
        wait_cycles(20);

        // 4: overrun at beat 7 and in the done cycle.
        issue_start(tile_a, 12'h200, 6'd8, 0);
        wait_cycles(7);
        tile_in   = tile_b;
        base_C    = 12'h003;
        dim_col_C = 6'd5;
        start     = 1'b1;
        ovr_q.push_back(cyc + 1);
        wait_cycles(1);
        start = 1'b0;
        chk("t4_busy", 128'(busy), 128'(1'b1));
        wait_cycles(8);
        chk("t4_done_hi", 128'(done), 128'(1'b1));
        start = 1'b1;
        ovr_q.push_back(cyc + 1);
        wait_cycles(1);
        start = 1'b0;
        wait_cycles(4);
        chk("t4_no_restart", 128'(write), 128'(1'b0));

        // 5: reset at beat 9, then clean restart with stride 0 and a negative word.
        issue_start(tile_c, 12'h040, 6'd0, 0);
        wait_cycles(9);
        reset = 1'b1;
        beat_q.delete();
        done_q.delete();
        #1;
        chk("t5_write_abort", 128'(write), 128'(1'b0));
        chk("t5_busy_abort", 128'(busy), 128'(1'b0));
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(2);
        issue_start(tile_c, 12'h040, 6'd0, 0);
        wait_cycles(20);

        chk("beats_left", 128'(beat_q.size()), 128'(0));
        chk("done_left", 128'(done_q.size()), 128'(0));
        chk("overrun_left", 128'(ovr_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
